// File: rtl/keccak_arbiter.sv
// Round-robin arbiter that lends one shared Keccak core to N_REQ requesters for a full absorb/squeeze transaction.
// Optional per-requester transaction counters are enabled by defining KECCAK_ARB_STATS_EN.
module keccak_arbiter #(
    parameter int N_REQ = 4,
    parameter int W     = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid_i,
    input  logic [N_REQ*W-1:0] req_data_i,
    input  logic [N_REQ-1:0]   req_last_i,
    output logic [N_REQ-1:0]   req_ready_o,
    output logic [N_REQ-1:0]   rsp_valid_o,
    output logic [W-1:0]       rsp_data_o,
    output logic               rsp_last_o,
    input  logic [N_REQ-1:0]   rsp_ready_i,
    output logic               core_valid_o,
    output logic [W-1:0]       core_data_o,
    input  logic               core_ready_i,
    input  logic               core_valid_i,
    input  logic [W-1:0]       core_data_i,
    input  logic               core_last_i,
    output logic               core_ready_o,
    output logic [N_REQ-1:0]   grant_o,
    output logic               busy_o
`ifdef KECCAK_ARB_STATS_EN
    ,
    output logic [N_REQ*16-1:0] txn_count_o
`endif
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {IDLE, ABSORB, SQUEEZE} state_t;

    state_t          state;
    logic [PW-1:0]   owner;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   winner;
    logic [PW:0]     cand;
    logic            found;
    logic [W-1:0]    sel_data;
    logic            in_sel;
    logic            out_sel;
    logic            absorb_done;
    logic            squeeze_done;

    // Search starts at ptr and wraps, so the most recent owner is considered last.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = {1'b0, ptr} + (PW+1)'(i);
            if (cand >= (PW+1)'(N_REQ))
                cand = cand - (PW+1)'(N_REQ);
            if (!found && req_valid_i[cand[PW-1:0]]) begin
                found  = 1'b1;
                winner = cand[PW-1:0];
            end
        end
    end

    always_comb begin
        sel_data = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (owner == PW'(k))
                sel_data = req_data_i[k*W +: W];
        end
    end

    assign in_sel       = (state == ABSORB);
    assign out_sel      = (state == SQUEEZE);
    assign absorb_done  = in_sel && req_valid_i[owner] && core_ready_i && req_last_i[owner];
    assign squeeze_done = out_sel && core_valid_i && rsp_ready_i[owner] && core_last_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            owner   <= '0;
            ptr     <= '0;
            grant_o <= '0;
            busy_o  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        state   <= ABSORB;
                        owner   <= winner;
                        grant_o <= {{(N_REQ-1){1'b0}}, 1'b1} << winner;
                        busy_o  <= 1'b1;
                    end
                end
                ABSORB: begin
                    if (absorb_done)
                        state <= SQUEEZE;
                end
                SQUEEZE: begin
                    if (squeeze_done) begin
                        state   <= IDLE;
                        grant_o <= '0;
                        busy_o  <= 1'b0;
                        ptr     <= (owner == PW'(N_REQ-1)) ? '0 : owner + 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    grant_o <= '0;
                    busy_o  <= 1'b0;
                end
            endcase
        end
    end

    // Both streams are straight pass-through of the owner's lane; grant_o doubles as the owner one-hot.
    assign core_valid_o = in_sel & req_valid_i[owner];
    assign core_data_o  = in_sel ? sel_data : '0;
    assign req_ready_o  = (in_sel && core_ready_i) ? grant_o : '0;

    assign rsp_valid_o  = (out_sel && core_valid_i) ? grant_o : '0;
    assign rsp_data_o   = out_sel ? core_data_i : '0;
    assign rsp_last_o   = out_sel & core_last_i;
    assign core_ready_o = out_sel & rsp_ready_i[owner];

`ifdef KECCAK_ARB_STATS_EN
    logic [15:0] txn_cnt [N_REQ];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_REQ; k++)
                txn_cnt[k] <= '0;
        end else if (squeeze_done && (txn_cnt[owner] != 16'hFFFF)) begin
            txn_cnt[owner] <= txn_cnt[owner] + 16'd1;
        end
    end

    for (genvar g = 0; g < N_REQ; g++) begin : g_cnt
        assign txn_count_o[g*16 +: 16] = txn_cnt[g];
    end
`endif

endmodule

// File: doc/keccak_arbiter.md
KECCAK_ARBITER -- requirements
Module: keccak_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, the number of requesters (2..8).
REQ-002 The block SHALL have parameter W, default 64, the data word width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 req_valid_i  in  N_REQ  per-requester input word valid.
REQ-006 req_data_i  in  N_REQ*W  per-requester input word; slice k is requester k.
REQ-007 req_last_i  in  N_REQ  marks the requester's final input word of a transaction.
REQ-008 req_ready_o  out  N_REQ  per-requester input accept.
REQ-009 rsp_valid_o  out  N_REQ  per-requester output word valid.
REQ-010 rsp_data_o  out  W  output word, shared by all requesters; qualified by rsp_valid_o.
REQ-011 rsp_last_o  out  1  final output word of the transaction.
REQ-012 rsp_ready_i  in  N_REQ  per-requester output accept.
REQ-013 core_valid_o, core_data_o[W], core_ready_i: the input stream to the shared Keccak core.
REQ-014 core_valid_i, core_data_i[W], core_last_i, core_ready_o: the output stream from the core.
REQ-015 grant_o  out  N_REQ  one-hot current owner; all zero when idle.
REQ-016 busy_o  out  1  high whenever the state is not IDLE.

Function
REQ-017 States: IDLE, ABSORB, SQUEEZE; encoding is free.
- IDLE -> ABSORB when any req_valid_i bit is set.
- ABSORB -> SQUEEZE on an input handshake with req_last_i of the owner set.
- SQUEEZE -> IDLE on an output handshake with core_last_i set.
REQ-018 In IDLE the block SHALL pick a winner by round-robin, starting the search at ptr.
- ptr resets to 0.
- On SQUEEZE->IDLE, ptr becomes (owner+1) mod N_REQ.
REQ-019 grant_o SHALL be registered: it asserts the cycle after the winning req_valid_i is sampled in IDLE (one-cycle arbitration latency). It holds until SQUEEZE->IDLE.
REQ-020 No word SHALL be accepted from any requester in IDLE; all req_ready_o are 0.
REQ-021 In ABSORB, the owner's signals SHALL pass through combinationally:
- core_valid_o = req_valid_i[owner]
- core_data_o = its data slice
- req_ready_o[owner] = core_ready_i
- all other req_ready_o = 0
REQ-022 Outside ABSORB, core_valid_o SHALL be 0.
REQ-023 In SQUEEZE, the output SHALL pass through combinationally:
- rsp_valid_o[owner] = core_valid_i
- rsp_data_o = core_data_i
- rsp_last_o = core_last_i
- core_ready_o = rsp_ready_i[owner]
REQ-024 Outside SQUEEZE, rsp_valid_o, rsp_last_o and core_ready_o SHALL be 0.
REQ-025 Core output words arriving in ABSORB SHALL be ignored; core_ready_o stays 0.
REQ-026 A requester deasserting req_valid_i mid-transaction SHALL NOT lose ownership. The block stalls until that requester resumes.
REQ-027 A single-word transaction (first word has req_last_i set) SHALL go ABSORB->SQUEEZE after that one handshake.
REQ-028 Requests from non-owners SHALL NOT affect ptr, grant_o or state until the block returns to IDLE.
REQ-029 A requester whose req_valid_i stays high continuously SHALL be granted within N_REQ transactions (no starvation).

Reset
REQ-030 While rst_n is low, the block SHALL asynchronously force:
- state = IDLE, ptr = 0, grant_o = 0, busy_o = 0
- all ready and valid outputs = 0
REQ-031 A reset asserted mid-transaction SHALL abandon that transaction. No output handshake may occur in the first cycle after rst_n deasserts.

Configuration
REQ-032 Macro KECCAK_ARB_STATS_EN, when defined, SHALL add:
- output txn_count_o[N_REQ*16]: one 16-bit counter per requester, slice k for requester k;
- requester k's counter increments on each SQUEEZE->IDLE exit where k is owner;
- counters saturate at 0xFFFF and reset to 0.
REQ-033 Without KECCAK_ARB_STATS_EN, the port and the counters SHALL be absent. All other behaviour is identical.

Verification
REQ-034 Reset then idle: rst_n low 3 cycles -> grant_o=0, busy_o=0, all req_ready_o=0.
REQ-035 Simultaneous request: requesters 1 and 2 raise valid together, each sends 3 words then takes 4 output words.
- grant_o=0b0010 first.
- After requester 1's 4th rsp handshake, grant_o=0b0100.
REQ-036 Round-robin fairness: all 4 requesters continuously valid, 1-word/1-word transactions -> owner order 0,1,2,3,0.
REQ-037 Backpressure: owner holds rsp_ready_i=0 for 5 cycles with core_valid_i=1 -> core_ready_o=0, rsp_data_o stable, no state change.
REQ-038 Mid-transaction reset: rst_n pulsed low during SQUEEZE -> state IDLE, grant_o=0. Next transaction granted to requester 0 if valid.
REQ-039 With KECCAK_ARB_STATS_EN: 3 transactions by requester 2 -> txn_count_o slice 2 = 3, all others 0.
